fetch_entry_arbiter: RTL and testbench

Shares the decode stage's single fetch-entry input between several instruction sources: frontend fetch queue, debug-module instruction injector, replay buffer. Sits directly in front of the decode stage's valid/ready fetch-entry port. Performs round-robin arbitration and holds a grant stable until the decode stage accepts the entry. Handles pipeline flushes and debug-mode source restriction.

---
 rtl/fetch_entry_arbiter.sv | 123 ++++++++++++
 tb/tb_fetch_entry_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fetch_entry_arbiter.sv
// Round-robin arbiter sharing the decode fetch-entry port between instruction sources.
// Define FETCH_ARB_STRICT_PRIO_EN to replace round-robin with fixed lowest-index priority.
module fetch_entry_arbiter #(
    parameter int NR_PORTS   = 2,
    parameter int ENTRY_W    = 64,
    parameter int DEBUG_PORT = 1,
    parameter int IDX_W      = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        debug_mode_i,
    input  logic [NR_PORTS-1:0]         req_valid_i,
    input  logic [NR_PORTS*ENTRY_W-1:0] req_entry_i,
    output logic [NR_PORTS-1:0]         req_ready_o,
    output logic [ENTRY_W-1:0]          fetch_entry_o,
    output logic                        fetch_entry_valid_o,
    input  logic                        fetch_entry_ready_i,
    output logic [IDX_W-1:0]            grant_idx_o,
    output logic                        locked_o
);
    typedef enum logic {ARB, HOLD} state_e;

    state_e                             state_q;
    logic [IDX_W-1:0]                   hold_idx_q;
    logic [IDX_W-1:0]                   scan_base;
    logic [NR_PORTS-1:0][ENTRY_W-1:0]   entries;
    logic [NR_PORTS-1:0]                dbg_mask;
    logic [NR_PORTS-1:0]                elig;
    logic [IDX_W:0]                     pick_res;
    logic                               win_vld;
    logic [IDX_W-1:0]                   win_idx;
    logic                               gnt_vld;
    logic [IDX_W-1:0]                   gnt_idx;
    logic                               hs;

    assign entries = req_entry_i;

    // First set bit of m scanning upward from base, wrapping at NR_PORTS.
    function automatic logic [IDX_W:0] pick(input logic [NR_PORTS-1:0] m,
                                            input logic [IDX_W-1:0]    base);
        logic [IDX_W:0] r;
        int             k;
        r = '0;
        for (int i = NR_PORTS - 1; i >= 0; i--) begin
            k = int'(base) + i;
            if (k >= NR_PORTS) k = k - NR_PORTS;
            if (m[IDX_W'(k)]) r = {1'b1, IDX_W'(k)};
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NR_PORTS - 1)) ? '0 : idx + 1'b1;
    endfunction

`ifdef FETCH_ARB_STRICT_PRIO_EN
    assign scan_base = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q;

    assign scan_base = rr_ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)   rr_ptr_q <= '0;
        else if (hs) rr_ptr_q <= nxt(gnt_idx);
    end
`endif

    always_comb begin
        dbg_mask             = '0;
        dbg_mask[DEBUG_PORT] = 1'b1;
        elig                 = req_valid_i & (debug_mode_i ? dbg_mask : {NR_PORTS{1'b1}});
        pick_res             = pick(elig, scan_base);
        win_vld              = pick_res[IDX_W];
        win_idx              = pick_res[IDX_W-1:0];
    end

    // Reset and flush blank every output; a held grant ignores masking and the pointer.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        locked_o = 1'b0;
        if (!rst_i && !flush_i) begin
            if (state_q == HOLD) begin
                gnt_vld  = 1'b1;
                gnt_idx  = hold_idx_q;
                locked_o = 1'b1;
            end else if (win_vld) begin
                gnt_vld = 1'b1;
                gnt_idx = win_idx;
            end
        end
        hs                   = gnt_vld & fetch_entry_ready_i;
        fetch_entry_valid_o  = gnt_vld;
        grant_idx_o          = gnt_idx;
        fetch_entry_o        = gnt_vld ? entries[gnt_idx] : '0;
        req_ready_o          = '0;
        req_ready_o[gnt_idx] = hs;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB;
            hold_idx_q <= '0;
        end else if (flush_i) begin
            state_q <= ARB;
        end else begin
            case (state_q)
                ARB: begin
                    if (win_vld && !fetch_entry_ready_i) begin
                        hold_idx_q <= win_idx;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (fetch_entry_ready_i) state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_entry_arbiter.sv
// Directed scoreboard bench for fetch_entry_arbiter: a 2-port and a 3-port instance.
module tb_fetch_entry_arbiter;
`ifdef FETCH_ARB_STRICT_PRIO_EN
    localparam bit S = 1'b1;
`else
    localparam bit S = 1'b0;
`endif

    typedef struct {
        logic        v;
        int          idx;
        logic [63:0] ent;
        logic [7:0]  rdy;
        logic        lk;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst2, fl2, dbg2, rdy2;
    logic [1:0]   vld2;
    logic [127:0] ent2;
    logic [1:0]   rr2o;
    logic [63:0]  fe2;
    logic         fev2, lk2;
    logic [0:0]   gi2;

    logic         rst3, fl3, dbg3, rdy3;
    logic [2:0]   vld3;
    logic [191:0] ent3;
    logic [2:0]   rr3o;
    logic [63:0]  fe3;
    logic         fev3, lk3;
    logic [1:0]   gi3;

    fetch_entry_arbiter #(.NR_PORTS(2), .ENTRY_W(64), .DEBUG_PORT(1)) dut2 (
        .clk_i(clk), .rst_i(rst2), .flush_i(fl2), .debug_mode_i(dbg2),
        .req_valid_i(vld2), .req_entry_i(ent2), .req_ready_o(rr2o),
        .fetch_entry_o(fe2), .fetch_entry_valid_o(fev2), .fetch_entry_ready_i(rdy2),
        .grant_idx_o(gi2), .locked_o(lk2)
    );

    fetch_entry_arbiter #(.NR_PORTS(3), .ENTRY_W(64), .DEBUG_PORT(1)) dut3 (
        .clk_i(clk), .rst_i(rst3), .flush_i(fl3), .debug_mode_i(dbg3),
        .req_valid_i(vld3), .req_entry_i(ent3), .req_ready_o(rr3o),
        .fetch_entry_o(fe3), .fetch_entry_valid_o(fev3), .fetch_entry_ready_i(rdy3),
        .grant_idx_o(gi3), .locked_o(lk3)
    );

    function automatic logic [63:0] ent(input int k);
        return 64'hDEAD_BEEF + (64'(k) << 32);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic ev, input int ei, input logic [7:0] er, input logic el);
        exp_t e;
        e.v   = ev;
        e.idx = ev ? ei : 0;
        e.ent = ev ? ent(ei) : 64'h0;
        e.rdy = er;
        e.lk  = el;
        sbq.push_back(e);
    endtask

    task automatic step2(input logic r, input logic f, input logic d, input logic rd,
                         input logic [1:0] v, input logic ev, input int ei,
                         input logic [7:0] er, input logic el);
        exp_t e;
        rst2 = r; fl2 = f; dbg2 = d; rdy2 = rd; vld2 = v;
        push(ev, ei, er, el);
        #4;
        e = sbq.pop_front();
        chk("p2_valid",  64'(fev2), 64'(e.v));
        chk("p2_idx",    64'(gi2),  64'(e.idx));
        chk("p2_entry",  fe2,       e.ent);
        chk("p2_ready",  64'(rr2o), 64'(e.rdy));
        chk("p2_locked", 64'(lk2),  64'(e.lk));
        @(posedge clk); #1;
    endtask

    task automatic step3(input logic r, input logic rd, input logic [2:0] v,
                         input logic ev, input int ei, input logic [7:0] er);
        exp_t e;
        rst3 = r; rdy3 = rd; vld3 = v;
        push(ev, ei, er, 1'b0);
        #4;
        e = sbq.pop_front();
        chk("p3_valid",  64'(fev3), 64'(e.v));
        chk("p3_idx",    64'(gi3),  64'(e.idx));
        chk("p3_entry",  fe3,       e.ent);
        chk("p3_ready",  64'(rr3o), 64'(e.rdy));
        chk("p3_locked", 64'(lk3),  64'(e.lk));
        @(posedge clk); #1;
    endtask

    initial begin
        ent2 = {ent(1), ent(0)};
        ent3 = {ent(2), ent(1), ent(0)};
        rst3 = 1'b1; fl3 = 1'b0; dbg3 = 1'b0; rdy3 = 1'b0; vld3 = '0;

        // Reset blanks outputs, then alternating grants with both ports valid
        step2(1, 0, 0, 1, 2'b11, 0, 0, 0, 0);
        step2(0, 0, 0, 1, 2'b11, 1, 0, 1, 0);
        step2(0, 0, 0, 1, 2'b11, 1, S ? 0 : 1, S ? 8'd1 : 8'd2, 0);
        step2(0, 0, 0, 1, 2'b11, 1, 0, 1, 0);
        step2(0, 0, 0, 1, 2'b11, 1, S ? 0 : 1, S ? 8'd1 : 8'd2, 0);

        // Stall on port 0, lock holds while port 1 joins, then transfer
        step2(0, 0, 0, 0, 2'b01, 1, 0, 0, 0);
        step2(0, 0, 0, 0, 2'b01, 1, 0, 0, 1);
        step2(0, 0, 0, 0, 2'b01, 1, 0, 0, 1);
        step2(0, 0, 0, 0, 2'b11, 1, 0, 0, 1);
        step2(0, 0, 0, 1, 2'b11, 1, 0, 1, 1);
        step2(0, 0, 0, 1, 2'b10, 1, 1, 2, 0);

        // Flush during HOLD on port 1 with ready: no transfer, pointer kept
        step2(0, 0, 0, 1, 2'b01, 1, 0, 1, 0);
        step2(0, 0, 0, 0, 2'b10, 1, 1, 0, 0);
        step2(0, 1, 0, 1, 2'b10, 0, 0, 0, 0);
        step2(0, 0, 0, 1, 2'b11, 1, S ? 0 : 1, S ? 8'd1 : 8'd2, 0);

        // Debug mode restricts to port 1; a held grant survives leaving debug
        step2(0, 0, 1, 1, 2'b11, 1, 1, 2, 0);
        step2(0, 0, 1, 1, 2'b11, 1, 1, 2, 0);
        step2(0, 0, 1, 0, 2'b11, 1, 1, 0, 0);
        step2(0, 0, 0, 0, 2'b11, 1, 1, 0, 1);
        step2(0, 0, 0, 1, 2'b11, 1, 1, 2, 1);

        // No eligible port, then reset while holding 0xDEADBEEF
        step2(0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        step2(0, 0, 0, 0, 2'b01, 1, 0, 0, 0);
        step2(1, 0, 0, 1, 2'b01, 0, 0, 0, 0);
        step2(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        step2(0, 0, 0, 1, 2'b10, 1, 1, 2, 0);

        // Three ports: wrap goes 2 -> 0
        step3(1, 1, 3'b111, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step3(0, 1, 3'b111, 1, S ? 0 : i % 3, 8'(1 << (S ? 0 : i % 3)));
        end

        if (sbq.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
